// File: rtl/conv_window_buffer.sv
// conv_window_buffer
//   Streaming KxK sliding-window generator (valid convolution, no padding).
//   Pixels arrive one per handshake in raster order; K-1 line buffers hold
//   the previous rows so that each accepted pixel completes one new window
//   column. Completed windows go to a single registered output slot with
//   valid/ready backpressure.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   clr        synchronous clear, same effect as reset
//   inValid    dataIn carries a pixel
//   inReady    block can accept a pixel this cycle
//   dataIn     pixel, raster order
//   outValid   windowOut/outRow/outCol hold a valid window
//   outReady   consumer takes the window this cycle
//   windowOut  element (r,c) at [(r*K+c)*DATA_W +: DATA_W], r=0 oldest row
//   outRow     image row of window element (0,0)
//   outCol     image column of window element (0,0)
//   frameDone  one-cycle pulse after the last window of a frame is taken
module conv_window_buffer #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       inValid,
    output logic                       inReady,
    input  logic [DATA_W-1:0]          dataIn,
    output logic                       outValid,
    input  logic                       outReady,
    output logic [K*K*DATA_W-1:0]      windowOut,
    output logic [$clog2(IMG_H)-1:0]   outRow,
    output logic [$clog2(IMG_W)-1:0]   outCol,
    output logic                       frameDone
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int WW = K*K*DATA_W;

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [CW-1:0] COL_LAST     = CW'(IMG_W-1);
    localparam logic [CW-1:0] COL_OFS      = CW'(K-1);
    localparam logic [CW-1:0] COL_LAST_WIN = CW'(IMG_W-K);
    localparam logic [RW-1:0] ROW_LAST     = RW'(IMG_H-1);
    localparam logic [RW-1:0] ROW_FILL_END = RW'(K-2);
    localparam logic [RW-1:0] ROW_OFS      = RW'(K-1);
    localparam logic [RW-1:0] ROW_LAST_WIN = RW'(IMG_H-K);

    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic [0:0]        r_state;
    logic [WW-1:0]     r_win;
    logic [DATA_W-1:0] r_lb [K-1][IMG_W];

    logic              r_out_valid;
    logic [WW-1:0]     r_out_win;
    logic [RW-1:0]     r_out_row;
    logic [CW-1:0]     r_out_col;
    logic              r_frame_done;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_produce;
    logic              w_out_take;
    logic [DATA_W-1:0] w_col_in [K];
    logic [WW-1:0]     w_win_next;

    assign w_in_ready = !clr && (!r_out_valid || outReady);
    assign w_accept   = inValid && w_in_ready;
    assign w_out_take = r_out_valid && outReady;
    assign w_produce  = w_accept && (r_state == S_RUN) && (r_col >= COL_OFS);

    // Incoming window column: rows 0..K-2 come from the line buffers at the
    // current column (read before this cycle's write), row K-1 is the pixel.
    always_comb begin
        for (int r = 0; r < K-1; r++) begin
            w_col_in[r] = r_lb[r][r_col];
        end
        w_col_in[K-1] = dataIn;
    end

    always_comb begin
        w_win_next = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                if (c < K-1) begin
                    w_win_next[(r*K+c)*DATA_W +: DATA_W] = r_win[(r*K+c+1)*DATA_W +: DATA_W];
                end else begin
                    w_win_next[(r*K+c)*DATA_W +: DATA_W] = w_col_in[r];
                end
            end
        end
    end

    // Storage that is never exposed without a refill: no reset needed.
    // Buffer r takes the column from buffer r+1, so buffer 0 is the oldest row.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_win <= w_win_next;
            for (int r = 0; r < K-1; r++) begin
                r_lb[r][r_col] <= w_col_in[r+1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col   <= '0;
            r_row   <= '0;
            r_state <= S_FILL;
        end else if (clr) begin
            r_col   <= '0;
            r_row   <= '0;
            r_state <= S_FILL;
        end else if (w_accept) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                if (r_row == ROW_LAST) begin
                    r_row   <= '0;
                    r_state <= S_FILL;
                end else begin
                    r_row <= r_row + 1'b1;
                    if (r_row == ROW_FILL_END) r_state <= S_RUN;
                end
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Output slot: a new window wins over the clear caused by a handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid  <= 1'b0;
            r_out_win    <= '0;
            r_out_row    <= '0;
            r_out_col    <= '0;
            r_frame_done <= 1'b0;
        end else if (clr) begin
            r_out_valid  <= 1'b0;
            r_out_win    <= '0;
            r_out_row    <= '0;
            r_out_col    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_out_take && (r_out_row == ROW_LAST_WIN) && (r_out_col == COL_LAST_WIN);
            if (w_produce) begin
                r_out_valid <= 1'b1;
                r_out_win   <= w_win_next;
                r_out_row   <= r_row - ROW_OFS;
                r_out_col   <= r_col - COL_OFS;
            end else if (w_out_take) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign inReady   = w_in_ready;
    assign outValid  = r_out_valid;
    assign windowOut = r_out_win;
    assign outRow    = r_out_row;
    assign outCol    = r_out_col;
    assign frameDone = r_frame_done;

endmodule

// File: tb/tb_conv_window_buffer.sv
module tb_conv_window_buffer;

    localparam int DW = 8;
    localparam int IW = 28;
    localparam int IH = 28;
    localparam int K  = 3;
    localparam int WW = K*K*DW;
    localparam int NPIX = IW*IH;
    localparam int NWIN = (IH-K+1)*(IW-K+1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          inValid = 1'b0;
    logic          inReady;
    logic [DW-1:0] dataIn = '0;
    logic          outValid;
    logic          outReady = 1'b1;
    logic [WW-1:0] windowOut;
    logic [4:0]    outRow;
    logic [4:0]    outCol;
    logic          frameDone;

    conv_window_buffer #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .K(K)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .inValid(inValid), .inReady(inReady), .dataIn(dataIn),
        .outValid(outValid), .outReady(outReady), .windowOut(windowOut),
        .outRow(outRow), .outCol(outCol), .frameDone(frameDone)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int            row;
        int            col;
        logic [WW-1:0] win;
    } win_t;

    logic [DW-1:0] img [IH][IW];
    int            pr = 0, pc = 0;        // position of next pixel in frame
    bit            m_valid = 0;
    logic [WW-1:0] m_win = '0;
    int            m_row = 0, m_col = 0;
    bit            m_fd = 0;
    int            acc_since = 0;
    bit            first_seen = 0;
    win_t          hist[$];               // windows the DUT handed over
    int            fd_cnt = 0;

    task automatic model_reset();
        pr = 0; pc = 0;
        m_valid = 0; m_win = '0; m_row = 0; m_col = 0; m_fd = 0;
        acc_since = 0; first_seen = 0;
    endtask

    always @(negedge clk) begin
        bit acc, hs, fdn, rdy;
        win_t w;
        if (!rst) model_reset();
        rdy = !clr && (!m_valid || outReady);
        chk("outValid", outValid, m_valid);
        chk("frameDone", frameDone, m_fd);
        chk("inReady", inReady, rdy);
        if (m_valid) begin
            chk("windowOut", windowOut, m_win);
            chk("outRow", outRow, m_row);
            chk("outCol", outCol, m_col);
        end
        if (rst) begin
            if (!first_seen && acc_since > 0 && m_valid && m_row == 0 && m_col == 0) begin
                first_seen = 1;
                chk("first_win_accepts", acc_since, 59);
                chk("first_win_valid", outValid, 1);
                chk("first_win_rowcol", {outRow, outCol}, 10'd0);
            end
            if (frameDone) fd_cnt++;
            if (!clr && outValid && outReady) begin
                w.row = outRow; w.col = outCol; w.win = windowOut;
                hist.push_back(w);
            end
            acc = inValid && rdy;
            hs  = m_valid && outReady;
            fdn = hs && m_row == IH-K && m_col == IW-K;
            if (clr) begin
                model_reset();
            end else begin
                if (acc) begin
                    if (pr == 0 && pc == 0) begin acc_since = 0; first_seen = 0; end
                    acc_since++;
                    img[pr][pc] = dataIn;
                    if (pr >= K-1 && pc >= K-1) begin
                        m_valid = 1;
                        m_row = pr-K+1;
                        m_col = pc-K+1;
                        for (int r = 0; r < K; r++)
                            for (int c = 0; c < K; c++)
                                m_win[(r*K+c)*DW +: DW] = img[m_row+r][m_col+c];
                    end else if (hs) begin
                        m_valid = 0;
                    end
                    pc++;
                    if (pc == IW) begin pc = 0; pr = (pr+1) % IH; end
                end else if (hs) begin
                    m_valid = 0;
                end
                m_fd = fdn;
            end
        end
    end

    // ---------------- stimulus ----------------
    int idx = 0;   // pattern index of the next pixel to offer

    function automatic logic [DW-1:0] pattern(input int i);
        int r, c;
        r = i / IW;
        c = i % IW;
        return DW'((r*IW + c) % 256);
    endfunction

    // mode 0 free, 1 backpressure once, 2 gapped input, 3 random everything
    task automatic send(input int n, input int mode);
        int  sent = 0, cyc = 0, hold = 0;
        bit  held = 0, acc;
        while (sent < n && cyc < n*8 + 200) begin
            case (mode)
                2:       inValid = (cyc % 2 == 0);
                3:       inValid = ($urandom_range(0, 3) != 0);
                default: inValid = 1'b1;
            endcase
            if (mode == 1) begin
                if (!held && outValid) begin held = 1; hold = 10; end
                outReady = (hold == 0);
                if (hold > 0) hold--;
            end else if (mode == 3) begin
                outReady = ($urandom_range(0, 2) != 0);
            end else begin
                outReady = 1'b1;
            end
            dataIn = (mode == 3) ? DW'($urandom) : pattern(idx);
            @(negedge clk);
            acc = inValid && inReady;
            @(posedge clk); #1;
            if (acc) begin sent++; idx = (idx + 1) % NPIX; end
            cyc++;
        end
        if (sent < n) chk("send_timeout", sent, n);
        inValid  = 1'b0;
        outReady = 1'b1;
    endtask

    task automatic drain();
        inValid = 1'b0; outReady = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    function automatic int seq_diffs(input int a, input int b, input int n);
        int d = 0;
        for (int i = 0; i < n; i++)
            if (hist[a+i].win !== hist[b+i].win || hist[a+i].row != hist[b+i].row ||
                hist[a+i].col != hist[b+i].col) d++;
        return d;
    endfunction

    logic [WW-1:0] first_win_exp;
    int h0, h1, f0;

    initial begin
        first_win_exp = 72'h3a39381e1d1c020100;

        // reset
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        chk("rst_outValid", outValid, 0);
        chk("rst_windowOut", windowOut, 0);
        chk("rst_frameDone", frameDone, 0);
        chk("rst_inReady", inReady, 1);
        @(posedge clk); #1;

        // single free-running frame
        h1 = hist.size(); f0 = fd_cnt;
        send(NPIX, 0); drain();
        chk("p1_windows", hist.size() - h1, NWIN);
        chk("p1_frameDone", fd_cnt - f0, 1);
        chk("p1_first_win", hist[h1].win, first_win_exp);
        chk("p1_first_rowcol", {hist[h1].row[4:0], hist[h1].col[4:0]}, 10'd0);
        chk("p1_last_row", hist[h1+NWIN-1].row, 25);
        chk("p1_last_col", hist[h1+NWIN-1].col, 25);
        chk("p1_last_e22", hist[h1+NWIN-1].win[WW-1 -: DW], 15);

        // backpressure
        h0 = hist.size(); f0 = fd_cnt;
        send(NPIX, 1); drain();
        chk("p2_windows", hist.size() - h0, NWIN);
        chk("p2_frameDone", fd_cnt - f0, 1);
        chk("p2_seq_diffs", seq_diffs(h1, h0, NWIN), 0);

        // gapped input
        h0 = hist.size(); f0 = fd_cnt;
        send(NPIX, 2); drain();
        chk("p3_windows", hist.size() - h0, NWIN);
        chk("p3_frameDone", fd_cnt - f0, 1);
        chk("p3_seq_diffs", seq_diffs(h1, h0, NWIN), 0);

        // back-to-back frames
        h0 = hist.size(); f0 = fd_cnt;
        send(2*NPIX, 0); drain();
        chk("p4_windows", hist.size() - h0, 2*NWIN);
        chk("p4_frameDone", fd_cnt - f0, 2);
        chk("p4_f2_first_win", hist[h0+NWIN].win, first_win_exp);
        chk("p4_seq_diffs", seq_diffs(h1, h0+NWIN, NWIN), 0);

        // random valid/ready and pixel values
        h0 = hist.size(); f0 = fd_cnt;
        send(NPIX, 3); drain();
        chk("p5_windows", hist.size() - h0, NWIN);
        chk("p5_frameDone", fd_cnt - f0, 1);

        // async reset mid-frame, then clr mid-frame
        send(100, 0);
        #2 rst = 1'b0;
        #1;
        chk("arst_outValid", outValid, 0);
        chk("arst_windowOut", windowOut, 0);
        chk("arst_rowcol", {outRow, outCol}, 10'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;
        idx = 0;
        send(70, 0);
        clr = 1'b1; inValid = 1'b1; dataIn = pattern(idx);
        @(posedge clk); #1;
        clr = 1'b0; inValid = 1'b0;
        chk("clr_outValid", outValid, 0);
        chk("clr_windowOut", windowOut, 0);
        idx = 0;
        h0 = hist.size(); f0 = fd_cnt;
        send(NPIX, 0); drain();
        chk("p6_windows", hist.size() - h0, NWIN);
        chk("p6_frameDone", fd_cnt - f0, 1);
        chk("p6_first_win", hist[h0].win, first_win_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
